// File: rtl/br_checkpoint_ctrl_if.sv
// Bus between rename/dispatch, the CDB, branch resolution and the
// branch checkpoint controller. The debug read port is present only when
// BR_CKPT_DEBUG_EN is defined.

`ifndef BR_STATE_W
`define BR_STATE_W    2
`endif
`ifndef BR_NONE
`define BR_NONE       2'b00
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'b01
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG   2'b10
`endif

interface br_checkpoint_ctrl_if #(parameter int DEPTH = 4);
    logic                     ckpt_req_i;
    logic [31:0][6:0]         ckpt_data_i;
    logic [DEPTH-1:0]         ckpt_tag_o;
    logic                     ckpt_gnt_o;
    logic                     full_o;
    logic [DEPTH-1:0]         live_mask_o;
    logic                     cdb_en_i;
    logic [5:0]               cdb_preg_i;
    logic                     resolve_en_i;
    logic [DEPTH-1:0]         resolve_tag_i;
    logic                     resolve_wrong_i;
    logic [`BR_STATE_W-1:0]   branch_state_o;
    logic [31:0][6:0]         rc_mt_all_data_o;
    logic [DEPTH-1:0]         squash_mask_o;
`ifdef BR_CKPT_DEBUG_EN
    logic [$clog2(DEPTH)-1:0] dbg_idx_i;
    logic [4:0]               dbg_areg_i;
    logic [6:0]               dbg_entry_o;
    logic                     dbg_valid_o;
    logic [15:0]              dbg_mispred_cnt_o;
`endif

    // Rename / resolve side: drives requests, consumes grants and recovery
    modport master (
`ifdef BR_CKPT_DEBUG_EN
        output dbg_idx_i, output dbg_areg_i,
        input  dbg_entry_o, input dbg_valid_o, input dbg_mispred_cnt_o,
`endif
        output ckpt_req_i, output ckpt_data_i, output cdb_en_i, output cdb_preg_i,
        output resolve_en_i, output resolve_tag_i, output resolve_wrong_i,
        input  ckpt_tag_o, input ckpt_gnt_o, input full_o, input live_mask_o,
        input  branch_state_o, input rc_mt_all_data_o, input squash_mask_o
    );

    // Checkpoint controller side
    modport slave (
`ifdef BR_CKPT_DEBUG_EN
        input  dbg_idx_i, input dbg_areg_i,
        output dbg_entry_o, output dbg_valid_o, output dbg_mispred_cnt_o,
`endif
        input  ckpt_req_i, input ckpt_data_i, input cdb_en_i, input cdb_preg_i,
        input  resolve_en_i, input resolve_tag_i, input resolve_wrong_i,
        output ckpt_tag_o, output ckpt_gnt_o, output full_o, output live_mask_o,
        output branch_state_o, output rc_mt_all_data_o, output squash_mask_o
    );
endinterface

// File: rtl/br_checkpoint_ctrl.sv
// Branch checkpoint controller for the rename stage. Each in-flight branch
// owns a slot holding a map-table snapshot (RDY bits kept current from the
// CDB) and a mask of older live slots. A mispredict drives the snapshot back
// into the map table in the same cycle and frees the slot plus every younger
// one. Optional debug port and mispredict counter: define BR_CKPT_DEBUG_EN.

`ifndef BR_STATE_W
`define BR_STATE_W    2
`endif
`ifndef BR_NONE
`define BR_NONE       2'b00
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'b01
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG   2'b10
`endif

module br_checkpoint_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    br_checkpoint_ctrl_if.slave bus
);
    typedef logic [31:0][6:0] map_t;

    logic [DEPTH-1:0] valid;
    map_t             snap [DEPTH];
    logic [DEPTH-1:0] dep  [DEPTH];

    logic [DEPTH-1:0] free_slots, alloc_tag, younger, squash, free_mask;
    logic             res_hit, wrong_ok, correct_ok, gnt;
    map_t             sel_snap;

    // Mark every entry whose preg matches the broadcast tag as ready
    function automatic map_t cdb_apply(input map_t d, input logic en, input logic [5:0] preg);
        map_t r;
        r = d;
        for (int a = 0; a < 32; a++)
            if (en && d[a][5:0] == preg) r[a][6] = 1'b1;
        return r;
    endfunction

    assign free_slots = ~valid;
    // Lowest clear bit of valid; zero once every slot is taken
    assign alloc_tag  = free_slots & (~free_slots + 1'b1);

    // A resolve naming a non-live slot is ignored entirely
    assign res_hit    = bus.resolve_en_i & |(bus.resolve_tag_i & valid);
    assign wrong_ok   = res_hit & bus.resolve_wrong_i;
    assign correct_ok = res_hit & ~bus.resolve_wrong_i;

    // The raw wrong-resolve flushes this cycle's dispatch, so it blocks the grant
    assign gnt = bus.ckpt_req_i & ~(&valid) & ~(bus.resolve_en_i & bus.resolve_wrong_i);

    assign bus.ckpt_tag_o  = alloc_tag;
    assign bus.ckpt_gnt_o  = gnt;
    assign bus.full_o      = &valid;
    assign bus.live_mask_o = valid;

    // Select the resolving snapshot and find live slots younger than it
    always_comb begin
        sel_snap = '0;
        younger  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.resolve_tag_i[i]) sel_snap = sel_snap | snap[i];
            if (valid[i] && |(dep[i] & bus.resolve_tag_i)) younger[i] = 1'b1;
        end
    end

    assign squash    = wrong_ok ? ((bus.resolve_tag_i & valid) | younger) : '0;
    assign free_mask = correct_ok ? (bus.resolve_tag_i & valid) : squash;

    assign bus.squash_mask_o    = squash;
    assign bus.rc_mt_all_data_o = wrong_ok ? cdb_apply(sel_snap, bus.cdb_en_i, bus.cdb_preg_i) : '0;
    assign bus.branch_state_o   = wrong_ok   ? `BR_PR_WRONG :
                                  correct_ok ? `BR_PR_CORRECT : `BR_NONE;

    // Slot allocation, release, dependency pruning and CDB wakeup
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dep[i]  <= '0;
                snap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (gnt && alloc_tag[i]) begin
                    // Older branches are whatever is live now, minus one retiring this cycle
                    valid[i] <= 1'b1;
                    snap[i]  <= cdb_apply(bus.ckpt_data_i, bus.cdb_en_i, bus.cdb_preg_i);
                    dep[i]   <= valid & ~free_mask;
                end else begin
                    if (free_mask[i]) valid[i] <= 1'b0;
                    dep[i] <= dep[i] & ~free_mask;
                    if (valid[i]) snap[i] <= cdb_apply(snap[i], bus.cdb_en_i, bus.cdb_preg_i);
                end
            end
        end
    end

`ifdef BR_CKPT_DEBUG_EN
    logic [15:0] mispred_cnt;

    // Saturating count of accepted mispredicts
    always_ff @(posedge clk) begin
        if (rst)                             mispred_cnt <= '0;
        else if (wrong_ok && ~&mispred_cnt) mispred_cnt <= mispred_cnt + 16'd1;
    end

    assign bus.dbg_entry_o       = snap[bus.dbg_idx_i][bus.dbg_areg_i];
    assign bus.dbg_valid_o       = valid[bus.dbg_idx_i];
    assign bus.dbg_mispred_cnt_o = mispred_cnt;
`endif

endmodule

// File: tb/tb_br_checkpoint_ctrl.sv
// Self-checking bench for br_checkpoint_ctrl: expected values are queued
// when stimulus is applied and popped when the outputs are sampled mid-cycle.

`ifndef BR_STATE_W
`define BR_STATE_W    2
`endif
`ifndef BR_NONE
`define BR_NONE       2'b00
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'b01
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG   2'b10
`endif

module tb_br_checkpoint_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;
    logic [31:0] exp_q [$];
    logic [31:0] e;

    br_checkpoint_ctrl_if #(.DEPTH(4)) bus ();
    br_checkpoint_ctrl #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ckpt_req_i      = 1'b0;
        bus.cdb_en_i        = 1'b0;
        bus.cdb_preg_i      = '0;
        bus.resolve_en_i    = 1'b0;
        bus.resolve_tag_i   = '0;
        bus.resolve_wrong_i = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic resolve(input logic [3:0] tag, input logic wrong);
        bus.resolve_en_i    = 1'b1;
        bus.resolve_tag_i   = tag;
        bus.resolve_wrong_i = wrong;
    endtask

    task automatic alloc_n(input int n);
        for (int k = 0; k < n; k++) begin
            idle();
            bus.ckpt_req_i = 1'b1;
            tick();
        end
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        exp_q.push_back(32'h0); exp_q.push_back(`BR_NONE); exp_q.push_back(32'h0);
        #4;
        e = exp_q.pop_front(); vecs++; if (bus.live_mask_o !== e[3:0]) begin errs++; $display("FAIL rst_live: got %b want %b", bus.live_mask_o, e[3:0]); end
        e = exp_q.pop_front(); vecs++; if (bus.full_o !== e[0]) begin errs++; $display("FAIL rst_full: got %b want %b", bus.full_o, e[0]); end
        e = exp_q.pop_front(); vecs++; if (bus.ckpt_tag_o !== e[3:0]) begin errs++; $display("FAIL rst_tag: got %b want %b", bus.ckpt_tag_o, e[3:0]); end
        e = exp_q.pop_front(); vecs++; if (bus.ckpt_gnt_o !== e[0]) begin errs++; $display("FAIL rst_gnt: got %b want %b", bus.ckpt_gnt_o, e[0]); end
        e = exp_q.pop_front(); vecs++; if (bus.branch_state_o !== e[1:0]) begin errs++; $display("FAIL rst_state: got %b want %b", bus.branch_state_o, e[1:0]); end
        e = exp_q.pop_front(); vecs++; if (bus.squash_mask_o !== e[3:0]) begin errs++; $display("FAIL rst_squash: got %b want %b", bus.squash_mask_o, e[3:0]); end
        tick();
    endtask

    task automatic test_alloc_full();
        for (int k = 0; k < 5; k++) begin
            idle();
            bus.ckpt_req_i = 1'b1;
            exp_q.push_back(k < 4 ? (32'h1 << k) : 32'h0);
            exp_q.push_back(k < 4 ? 32'h1 : 32'h0);
            exp_q.push_back(k < 4 ? 32'h0 : 32'h1);
            #4;
            e = exp_q.pop_front(); vecs++; if (bus.ckpt_tag_o !== e[3:0]) begin errs++; $display("FAIL alloc_tag%0d: got %b want %b", k, bus.ckpt_tag_o, e[3:0]); end
            e = exp_q.pop_front(); vecs++; if (bus.ckpt_gnt_o !== e[0]) begin errs++; $display("FAIL alloc_gnt%0d: got %b want %b", k, bus.ckpt_gnt_o, e[0]); end
            e = exp_q.pop_front(); vecs++; if (bus.full_o !== e[0]) begin errs++; $display("FAIL alloc_full%0d: got %b want %b", k, bus.full_o, e[0]); end
            tick();
        end
        idle();
    endtask

    task automatic test_cdb_recovery();
        do_reset();
        for (int a = 0; a < 32; a++) bus.ckpt_data_i[a] = 7'(a);
        bus.ckpt_data_i[3] = 7'd40;
        bus.ckpt_data_i[7] = 7'd40;
        bus.ckpt_req_i = 1'b1;
        exp_q.push_back(32'h1);
        #4;
        e = exp_q.pop_front(); vecs++; if (bus.ckpt_gnt_o !== e[0]) begin errs++; $display("FAIL cdb_gnt: got %b want %b", bus.ckpt_gnt_o, e[0]); end
        tick();
        idle();
        bus.cdb_en_i = 1'b1;
        bus.cdb_preg_i = 6'd40;
        tick();
        // Wrong resolve with a same-cycle CDB of preg 5
        idle();
        resolve(4'b0001, 1'b1);
        bus.cdb_en_i = 1'b1;
        bus.cdb_preg_i = 6'd5;
        exp_q.push_back({25'h0, 1'b1, 6'd40}); exp_q.push_back({25'h0, 1'b1, 6'd40});
        exp_q.push_back({25'h0, 1'b1, 6'd5});  exp_q.push_back({25'h0, 1'b0, 6'd9});
        exp_q.push_back(`BR_PR_WRONG); exp_q.push_back(32'h1);
        #4;
        e = exp_q.pop_front(); vecs++; if (bus.rc_mt_all_data_o[3] !== e[6:0]) begin errs++; $display("FAIL rc_areg3: got %h want %h", bus.rc_mt_all_data_o[3], e[6:0]); end
        e = exp_q.pop_front(); vecs++; if (bus.rc_mt_all_data_o[7] !== e[6:0]) begin errs++; $display("FAIL rc_areg7: got %h want %h", bus.rc_mt_all_data_o[7], e[6:0]); end
        e = exp_q.pop_front(); vecs++; if (bus.rc_mt_all_data_o[5] !== e[6:0]) begin errs++; $display("FAIL rc_areg5: got %h want %h", bus.rc_mt_all_data_o[5], e[6:0]); end
        e = exp_q.pop_front(); vecs++; if (bus.rc_mt_all_data_o[9] !== e[6:0]) begin errs++; $display("FAIL rc_areg9: got %h want %h", bus.rc_mt_all_data_o[9], e[6:0]); end
        e = exp_q.pop_front(); vecs++; if (bus.branch_state_o !== e[1:0]) begin errs++; $display("FAIL rc_state: got %b want %b", bus.branch_state_o, e[1:0]); end
        e = exp_q.pop_front(); vecs++; if (bus.squash_mask_o !== e[3:0]) begin errs++; $display("FAIL rc_squash: got %b want %b", bus.squash_mask_o, e[3:0]); end
        tick();
        idle();
        exp_q.push_back(32'h0);
        #4;
        e = exp_q.pop_front(); vecs++; if (bus.live_mask_o !== e[3:0]) begin errs++; $display("FAIL rc_live: got %b want %b", bus.live_mask_o, e[3:0]); end
        tick();
    endtask

    task automatic test_squash();
        do_reset();
        alloc_n(3);
        resolve(4'b0010, 1'b1);
        exp_q.push_back(32'h6); exp_q.push_back(`BR_PR_WRONG);
        #4;
        e = exp_q.pop_front(); vecs++; if (bus.squash_mask_o !== e[3:0]) begin errs++; $display("FAIL sq_mask: got %b want %b", bus.squash_mask_o, e[3:0]); end
        e = exp_q.pop_front(); vecs++; if (bus.branch_state_o !== e[1:0]) begin errs++; $display("FAIL sq_state: got %b want %b", bus.branch_state_o, e[1:0]); end
        tick();
        idle();
        exp_q.push_back(32'h1);
        #4;
        e = exp_q.pop_front(); vecs++; if (bus.live_mask_o !== e[3:0]) begin errs++; $display("FAIL sq_live: got %b want %b", bus.live_mask_o, e[3:0]); end
        tick();
    endtask

    task automatic test_correct();
        do_reset();
        alloc_n(2);
        resolve(4'b0001, 1'b0);
        exp_q.push_back(`BR_PR_CORRECT); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #4;
        e = exp_q.pop_front(); vecs++; if (bus.branch_state_o !== e[1:0]) begin errs++; $display("FAIL cor_state: got %b want %b", bus.branch_state_o, e[1:0]); end
        e = exp_q.pop_front(); vecs++; if (bus.squash_mask_o !== e[3:0]) begin errs++; $display("FAIL cor_squash: got %b want %b", bus.squash_mask_o, e[3:0]); end
        e = exp_q.pop_front(); vecs++; if (bus.rc_mt_all_data_o[3] !== e[6:0]) begin errs++; $display("FAIL cor_rc: got %h want %h", bus.rc_mt_all_data_o[3], e[6:0]); end
        tick();
        idle();
        exp_q.push_back(32'h2);
        #4;
        e = exp_q.pop_front(); vecs++; if (bus.live_mask_o !== e[3:0]) begin errs++; $display("FAIL cor_live: got %b want %b", bus.live_mask_o, e[3:0]); end
        tick();
        resolve(4'b0010, 1'b1);
        exp_q.push_back(32'h2);
        #4;
        e = exp_q.pop_front(); vecs++; if (bus.squash_mask_o !== e[3:0]) begin errs++; $display("FAIL cor_sq2: got %b want %b", bus.squash_mask_o, e[3:0]); end
        tick();
        idle();
    endtask

    task automatic test_full_correct();
        do_reset();
        alloc_n(4);
        resolve(4'b0100, 1'b0);
        bus.ckpt_req_i = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(`BR_PR_CORRECT); exp_q.push_back(32'hF);
        #4;
        e = exp_q.pop_front(); vecs++; if (bus.ckpt_gnt_o !== e[0]) begin errs++; $display("FAIL fc_gnt: got %b want %b", bus.ckpt_gnt_o, e[0]); end
        e = exp_q.pop_front(); vecs++; if (bus.branch_state_o !== e[1:0]) begin errs++; $display("FAIL fc_state: got %b want %b", bus.branch_state_o, e[1:0]); end
        e = exp_q.pop_front(); vecs++; if (bus.live_mask_o !== e[3:0]) begin errs++; $display("FAIL fc_live: got %b want %b", bus.live_mask_o, e[3:0]); end
        tick();
        idle();
        bus.ckpt_req_i = 1'b1;
        exp_q.push_back(32'h4); exp_q.push_back(32'h1);
        #4;
        e = exp_q.pop_front(); vecs++; if (bus.ckpt_tag_o !== e[3:0]) begin errs++; $display("FAIL fc_tag: got %b want %b", bus.ckpt_tag_o, e[3:0]); end
        e = exp_q.pop_front(); vecs++; if (bus.ckpt_gnt_o !== e[0]) begin errs++; $display("FAIL fc_gnt2: got %b want %b", bus.ckpt_gnt_o, e[0]); end
        tick();
        idle();
    endtask

    // Continues from full: slot 2 was re-allocated after slot 3, so it is younger
    task automatic test_wrong_req();
        resolve(4'b1000, 1'b1);
        bus.ckpt_req_i = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'hC);
        #4;
        e = exp_q.pop_front(); vecs++; if (bus.ckpt_gnt_o !== e[0]) begin errs++; $display("FAIL wr_gnt: got %b want %b", bus.ckpt_gnt_o, e[0]); end
        e = exp_q.pop_front(); vecs++; if (bus.squash_mask_o !== e[3:0]) begin errs++; $display("FAIL wr_squash: got %b want %b", bus.squash_mask_o, e[3:0]); end
        tick();
        idle();
        exp_q.push_back(32'h3); exp_q.push_back(32'h0);
        #4;
        e = exp_q.pop_front(); vecs++; if (bus.live_mask_o !== e[3:0]) begin errs++; $display("FAIL wr_live: got %b want %b", bus.live_mask_o, e[3:0]); end
        e = exp_q.pop_front(); vecs++; if (bus.full_o !== e[0]) begin errs++; $display("FAIL wr_full: got %b want %b", bus.full_o, e[0]); end
        tick();
    endtask

    task automatic test_invalid_resolve();
        alloc_n(1);
        resolve(4'b1000, 1'b1);
        exp_q.push_back(`BR_NONE); exp_q.push_back(32'h0);
        #4;
        e = exp_q.pop_front(); vecs++; if (bus.branch_state_o !== e[1:0]) begin errs++; $display("FAIL inv_state: got %b want %b", bus.branch_state_o, e[1:0]); end
        e = exp_q.pop_front(); vecs++; if (bus.squash_mask_o !== e[3:0]) begin errs++; $display("FAIL inv_squash: got %b want %b", bus.squash_mask_o, e[3:0]); end
        tick();
        idle();
        exp_q.push_back(32'h7);
        #4;
        e = exp_q.pop_front(); vecs++; if (bus.live_mask_o !== e[3:0]) begin errs++; $display("FAIL inv_live: got %b want %b", bus.live_mask_o, e[3:0]); end
        tick();
    endtask

    task automatic test_rst_mid();
        rst = 1'b1;
        bus.ckpt_req_i = 1'b1;
        resolve(4'b0001, 1'b0);
        tick();
        rst = 1'b0;
        idle();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        #4;
        e = exp_q.pop_front(); vecs++; if (bus.live_mask_o !== e[3:0]) begin errs++; $display("FAIL rm_live: got %b want %b", bus.live_mask_o, e[3:0]); end
        e = exp_q.pop_front(); vecs++; if (bus.full_o !== e[0]) begin errs++; $display("FAIL rm_full: got %b want %b", bus.full_o, e[0]); end
        e = exp_q.pop_front(); vecs++; if (bus.ckpt_tag_o !== e[3:0]) begin errs++; $display("FAIL rm_tag: got %b want %b", bus.ckpt_tag_o, e[3:0]); end
        tick();
    endtask

    initial begin
        bus.ckpt_data_i = '0;
`ifdef BR_CKPT_DEBUG_EN
        bus.dbg_idx_i  = '0;
        bus.dbg_areg_i = '0;
`endif
        idle();
        test_reset();
        test_alloc_full();
        test_cdb_recovery();
        test_squash();
        test_correct();
        test_full_correct();
        test_wrong_req();
        test_invalid_resolve();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
